// File: rtl/l2_write_buffer_pkg.sv
// Shared types for the L2 write-back buffer: line data, line tag and the control FSM state.
package l2_write_buffer_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [255:0] lc3b_l2line;
    typedef logic [10:0]  lc3b_wb_tag;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP,
        S_READ,
        S_DRAIN
    } lc3b_wb_state;

    function automatic lc3b_word wb_line_addr(lc3b_wb_tag tag);
        return {tag, 5'b0};
    endfunction

endpackage

// File: rtl/l2_wb_storage.sv
// Circular FIFO of buffered L2 lines with in-place update and a parallel tag lookup.
module l2_wb_storage
    import l2_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic [10:0]     lookup_tag_i,
    output logic            hit_o,
    output logic [PtrW-1:0] hit_idx_o,
    output logic [255:0]    hit_data_o,
    input  logic            push_i,
    input  logic [10:0]     push_tag_i,
    input  logic [255:0]    push_data_i,
    input  logic            upd_i,
    input  logic [PtrW-1:0] upd_idx_i,
    input  logic [255:0]    upd_data_i,
    input  logic            pop_i,
    output logic [10:0]     head_tag_o,
    output logic [255:0]    head_data_o,
    output logic            empty_o,
    output logic            full_o
);

    logic [DEPTH-1:0] valid_q;
    lc3b_wb_tag       tag_q  [DEPTH];
    lc3b_l2line       data_q [DEPTH];
    logic [PtrW-1:0]  head_q, tail_q;
    logic [PtrW:0]    count_q;
    logic             push_en, pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    // Guards keep count inside [0, DEPTH] even if the controller misbehaves.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrW'(1);
            end
            if (pop_en) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            tag_q[tail_q]  <= push_tag_i;
            data_q[tail_q] <= push_data_i;
        end
        if (upd_i) begin
            data_q[upd_idx_i] <= upd_data_i;
        end
    end

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = PtrW'(i);
            end
        end
    end

    assign hit_data_o  = data_q[hit_idx_o];
    assign head_tag_o  = tag_q[head_q];
    assign head_data_o = data_q[head_q];

endmodule

// File: rtl/l2_write_buffer.sv
// Write-back buffer between the L2 pmem port and memory: absorbs evictions, serves read hits,
// drains to memory whenever no L2 request is pending.
module l2_write_buffer
    import l2_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         l2_read_i,
    input  logic         l2_write_i,
    input  logic [15:0]  l2_address_i,
    input  logic [255:0] l2_wdata_i,
    output logic         l2_resp_o,
    output logic [255:0] l2_rdata_o,
    output logic         pmem_read_o,
    output logic         pmem_write_o,
    output logic [15:0]  pmem_address_o,
    output logic [255:0] pmem_wdata_o,
    input  logic         pmem_resp_i,
    input  logic [255:0] pmem_rdata_i,
    output logic         wb_empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    lc3b_wb_state    state_q, state_d;
    lc3b_l2line      rdata_q, rdata_d;

    logic            hit;
    logic [PtrW-1:0] hit_idx;
    lc3b_l2line      hit_data;
    logic            push, upd, pop;
    lc3b_wb_tag      head_tag;
    lc3b_l2line      head_data;
    logic            empty, full;
    lc3b_wb_tag      req_tag;
    logic            unused_addr_low;

    assign req_tag         = l2_address_i[15:5];
    assign unused_addr_low = ^l2_address_i[4:0];

    l2_wb_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .lookup_tag_i (req_tag),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .hit_data_o   (hit_data),
        .push_i       (push),
        .push_tag_i   (req_tag),
        .push_data_i  (l2_wdata_i),
        .upd_i        (upd),
        .upd_idx_i    (hit_idx),
        .upd_data_i   (l2_wdata_i),
        .pop_i        (pop),
        .head_tag_o   (head_tag),
        .head_data_o  (head_data),
        .empty_o      (empty),
        .full_o       (full)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rdata_d        = rdata_q;
        push           = 1'b0;
        upd            = 1'b0;
        pop            = 1'b0;
        l2_resp_o      = 1'b0;
        pmem_read_o    = 1'b0;
        pmem_write_o   = 1'b0;
        pmem_address_o = '0;
        pmem_wdata_o   = '0;
        unique case (state_q)
            S_IDLE: begin
                // Reads outrank writes, and any L2 request outranks a background drain.
                if (l2_read_i) begin
                    if (hit) begin
                        rdata_d = hit_data;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_READ;
                    end
                end else if (l2_write_i) begin
                    if (hit) begin
                        upd     = 1'b1;
                        state_d = S_RESP;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (!empty) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                l2_resp_o = 1'b1;
                state_d   = S_IDLE;
            end
            S_READ: begin
                pmem_read_o    = 1'b1;
                pmem_address_o = wb_line_addr(req_tag);
                if (pmem_resp_i) begin
                    rdata_d = pmem_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_DRAIN: begin
                pmem_write_o   = 1'b1;
                pmem_address_o = wb_line_addr(head_tag);
                pmem_wdata_o   = head_data;
                if (pmem_resp_i) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign l2_rdata_o = rdata_q;
    assign wb_empty_o = empty;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Self-checking bench for l2_write_buffer: directed timing scenarios plus a randomized
// read/write mix checked against a last-writer-wins line model and a memory responder.
module tb_l2_write_buffer;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         l2_read = 1'b0, l2_write = 1'b0;
    logic [15:0]  l2_address = '0;
    logic [255:0] l2_wdata = '0;
    logic         l2_resp;
    logic [255:0] l2_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         wb_empty;

    logic         mem_en = 1'b0;
    logic         man_resp = 1'b0, auto_resp = 1'b0;
    logic [255:0] man_rdata = '0, auto_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Responder state and observations.
    logic [255:0] mem [logic [10:0]];
    logic [271:0] drain_log [$];
    int           busy = 0, lat_now = 0, pmem_viol = 0, rd_cmd_cnt = 0, wr_cmd_cnt = 0;
    logic [15:0]  cmd_addr;
    logic [255:0] cmd_data;
    logic         cmd_wr;

    always #5 clk = ~clk;

    assign pmem_resp  = mem_en ? auto_resp : man_resp;
    assign pmem_rdata = mem_en ? auto_rdata : man_rdata;

    l2_write_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .l2_read_i      (l2_read),
        .l2_write_i     (l2_write),
        .l2_address_i   (l2_address),
        .l2_wdata_i     (l2_wdata),
        .l2_resp_o      (l2_resp),
        .l2_rdata_o     (l2_rdata),
        .pmem_read_o    (pmem_read),
        .pmem_write_o   (pmem_write),
        .pmem_address_o (pmem_address),
        .pmem_wdata_o   (pmem_wdata),
        .pmem_resp_i    (pmem_resp),
        .pmem_rdata_i   (pmem_rdata),
        .wb_empty_o     (wb_empty)
    );

    function automatic logic [255:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] mem_default(logic [10:0] t);
        return {8{21'h1AB5C, t}};
    endfunction

    function automatic logic [255:0] mem_read(logic [10:0] t);
        if (mem.exists(t)) return mem[t];
        return mem_default(t);
    endfunction

    // Memory model: random latency, records drains, flags unstable or unaligned commands.
    initial begin
        forever begin
            @(negedge clk);
            auto_resp = 1'b0;
            if (pmem_read === 1'b1) rd_cmd_cnt++;
            if (pmem_write === 1'b1) wr_cmd_cnt++;
            if (mem_en !== 1'b1 || !(pmem_read === 1'b1 || pmem_write === 1'b1)) begin
                busy = 0;
            end else begin
                if (busy == 0) begin
                    cmd_addr = pmem_address;
                    cmd_data = pmem_wdata;
                    cmd_wr   = pmem_write;
                    lat_now  = $urandom_range(0, 3);
                    if (cmd_addr[4:0] != 5'd0) pmem_viol++;
                end else if (pmem_address !== cmd_addr || (cmd_wr && pmem_wdata !== cmd_data)) begin
                    pmem_viol++;
                end
                busy++;
                if (busy > lat_now) begin
                    auto_resp = 1'b1;
                    busy      = 0;
                    if (cmd_wr) begin
                        mem[cmd_addr[15:5]] = cmd_data;
                        drain_log.push_back({cmd_addr, cmd_data});
                    end else begin
                        auto_rdata = mem_read(cmd_addr[15:5]);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion, want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks: start at a negedge, return at the negedge where l2_resp is seen (lat = -1 on timeout).
    task automatic do_write(input logic [15:0] a, input logic [255:0] d, input int budget,
                            output int lat);
        l2_address = a;
        l2_wdata   = d;
        l2_write   = 1'b1;
        lat        = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (l2_resp === 1'b1) begin
                lat = i;
                break;
            end
        end
        l2_write = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input int budget, output int lat,
                           output logic [255:0] data);
        l2_address = a;
        l2_read    = 1'b1;
        lat        = -1;
        data       = 'x;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (l2_resp === 1'b1) begin
                lat  = i;
                data = l2_rdata;
                break;
            end
        end
        l2_read = 1'b0;
    endtask

    task automatic wait_pmem_write(input int budget, output int n);
        n = -1;
        for (int i = 0; i <= budget; i++) begin
            if (pmem_write === 1'b1) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_resp();
        man_resp = 1'b1;
        @(negedge clk);
        man_resp = 1'b0;
    endtask

    task automatic test_reset();
        int act;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if ({l2_resp, pmem_read, pmem_write} !== 3'b000) begin
            n_errors++;
            $display("FAIL rst_ctl: got resp/rd/wr=%b want 000", {l2_resp, pmem_read, pmem_write});
        end
        n_checks++;
        if ({l2_rdata, pmem_address, pmem_wdata} !== '0) begin
            n_errors++;
            $display("FAIL rst_data: got rdata=%h addr=%h wdata=%h want all 0",
                     l2_rdata, pmem_address, pmem_wdata);
        end
        n_checks++;
        if (wb_empty !== 1'b1) begin n_errors++; $display("FAIL rst_empty: got %b want 1", wb_empty); end
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || l2_resp !== 1'b0) act++;
        end
        n_checks++;
        if (act !== 0) begin n_errors++; $display("FAIL rst_idle: got %0d active cycles want 0", act); end
    endtask

    task automatic test_write_drain();
        logic [255:0] a_data;
        int lat, n;
        a_data = rand_line();
        do_write(16'h1240, a_data, 4, lat);
        n_checks++;
        if (lat !== 1) begin n_errors++; $display("FAIL wd_lat: got %0d want 1", lat); end
        n_checks++;
        if (wb_empty !== 1'b0) begin n_errors++; $display("FAIL wd_notempty: got %b want 0", wb_empty); end
        wait_pmem_write(6, n);
        n_checks++;
        if ({pmem_address, pmem_wdata} !== {16'h1240, a_data}) begin
            n_errors++;
            $display("FAIL wd_drain: got n=%0d addr=%h data=%h want addr=1240 data=%h",
                     n, pmem_address, pmem_wdata, a_data);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pmem_write, pmem_address, pmem_wdata} !== {1'b1, 16'h1240, a_data}) begin
            n_errors++;
            $display("FAIL wd_hold: got wr=%b addr=%h want held command", pmem_write, pmem_address);
        end
        pulse_resp();
        n_checks++;
        if ({wb_empty, pmem_write} !== 2'b10) begin
            n_errors++;
            $display("FAIL wd_popped: got empty/wr=%b want 10", {wb_empty, pmem_write});
        end
    endtask

    task automatic test_read_hit();
        logic [255:0] b, got;
        int lat, rd0, n;
        b   = rand_line();
        rd0 = rd_cmd_cnt;
        do_write(16'h2000, b, 4, lat);
        n_checks++;
        if (lat !== 1) begin n_errors++; $display("FAIL rh_wlat: got %0d want 1", lat); end
        // Issued as the write completes; accepted on the next S_IDLE edge, ahead of the drain.
        do_read(16'h2010, 4, lat, got);
        n_checks++;
        if (lat !== 2) begin n_errors++; $display("FAIL rh_rlat: got %0d want 2", lat); end
        n_checks++;
        if (got !== b) begin n_errors++; $display("FAIL rh_data: got %h want %h", got, b); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (rd_cmd_cnt !== rd0) begin
            n_errors++;
            $display("FAIL rh_nopmem: got %0d pmem_read cycles want 0", rd_cmd_cnt - rd0);
        end
        wait_pmem_write(2, n);
        n_checks++;
        if ({pmem_write, pmem_address, pmem_wdata} !== {1'b1, 16'h2000, b}) begin
            n_errors++;
            $display("FAIL rh_drain: got wr=%b addr=%h want wr=1 addr=2000", pmem_write, pmem_address);
        end
        pulse_resp();
        n_checks++;
        if (wb_empty !== 1'b1) begin n_errors++; $display("FAIL rh_empty: got %b want 1", wb_empty); end
    endtask

    task automatic test_coalesce();
        logic [255:0] c, d;
        int lat, n, w0;
        c = rand_line();
        d = rand_line();
        do_write(16'h3000, c, 4, lat);
        do_write(16'h301F, d, 4, lat);
        n_checks++;
        if (lat !== 2) begin n_errors++; $display("FAIL co_lat: got %0d want 2", lat); end
        wait_pmem_write(6, n);
        n_checks++;
        if ({pmem_write, pmem_address, pmem_wdata} !== {1'b1, 16'h3000, d}) begin
            n_errors++;
            $display("FAIL co_drain: got addr=%h data=%h want addr=3000 data=%h",
                     pmem_address, pmem_wdata, d);
        end
        pulse_resp();
        w0 = wr_cmd_cnt;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({wb_empty, 32'(wr_cmd_cnt - w0)} !== {1'b1, 32'd0}) begin
            n_errors++;
            $display("FAIL co_single: got empty=%b extra drains=%0d want 1 and 0",
                     wb_empty, wr_cmd_cnt - w0);
        end
    endtask

    task automatic test_full_wrap();
        logic [271:0] expq [$];
        logic [255:0] d;
        logic [15:0]  a;
        int lat, seen, fails;
        for (int i = 0; i < 4; i++) begin
            a = 16'h5000 + 16'(i * 32);
            d = rand_line();
            do_write(a, d, 4, lat);
            n_checks++;
            if (lat !== ((i == 0) ? 1 : 2)) begin
                n_errors++;
                $display("FAIL fw_fill%0d: got lat %0d want %0d", i, lat, (i == 0) ? 1 : 2);
            end
            expq.push_back({a, d});
        end
        a          = 16'h5080;
        d          = rand_line();
        l2_address = a;
        l2_wdata   = d;
        l2_write   = 1'b1;
        seen       = 0;
        repeat (6) begin
            @(negedge clk);
            if (l2_resp === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL fw_block: got %0d resp want 0", seen); end
        n_checks++;
        if ({pmem_write, pmem_address, pmem_wdata} !== {1'b1, expq[0]}) begin
            n_errors++;
            $display("FAIL fw_head: got wr=%b addr=%h want wr=1 addr=%h",
                     pmem_write, pmem_address, expq[0][271:256]);
        end
        pulse_resp();
        n_checks++;
        if (l2_resp !== 1'b0) begin n_errors++; $display("FAIL fw_early: got %b want 0", l2_resp); end
        @(negedge clk);
        n_checks++;
        if (l2_resp !== 1'b1) begin n_errors++; $display("FAIL fw_ack: got %b want 1", l2_resp); end
        l2_write = 1'b0;
        void'(expq.pop_front());
        expq.push_back({a, d});

        drain_log.delete();
        mem_en = 1'b1;
        fails  = 0;
        for (int i = 0; i < 12; i++) begin
            a = 16'h5000 + 16'((5 + i) * 32);
            d = rand_line();
            do_write(a | 16'($urandom_range(0, 31)), d, 40, lat);
            if (lat < 0) fails++;
            expq.push_back({a, d});
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        n_checks++;
        if (fails !== 0) begin n_errors++; $display("FAIL fw_wrap_ack: got %0d timeouts want 0", fails); end
        for (int i = 0; i < 300 && !(wb_empty === 1'b1 && pmem_write === 1'b0); i++) @(negedge clk);
        n_checks++;
        if (wb_empty !== 1'b1) begin n_errors++; $display("FAIL fw_flush: got %b want 1", wb_empty); end
        n_checks++;
        if (drain_log.size() !== expq.size()) begin
            n_errors++;
            $display("FAIL fw_count: got %0d drains want %0d", drain_log.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < drain_log.size(); i++) begin
            n_checks++;
            if (drain_log[i] !== expq[i]) begin
                n_errors++;
                $display("FAIL fw_order%0d: got addr %h want addr %h", i,
                         drain_log[i][271:256], expq[i][271:256]);
            end
        end
        n_checks++;
        if (pmem_viol !== 0) begin n_errors++; $display("FAIL fw_stable: got %0d violations want 0", pmem_viol); end
        mem_en = 1'b0;
    endtask

    task automatic test_read_miss();
        logic [255:0] e;
        int bad;
        e          = rand_line();
        l2_address = 16'h4000;
        l2_read    = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pmem_read, pmem_address, l2_resp} !== {1'b1, 16'h4000, 1'b0}) begin
            n_errors++;
            $display("FAIL rm_issue: got rd=%b addr=%h resp=%b want 1 4000 0",
                     pmem_read, pmem_address, l2_resp);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if ({pmem_read, pmem_address, l2_resp} !== {1'b1, 16'h4000, 1'b0}) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL rm_hold: got %0d bad cycles want 0", bad); end
        man_rdata = e;
        pulse_resp();
        n_checks++;
        if ({l2_resp, pmem_read, l2_rdata} !== {2'b10, e}) begin
            n_errors++;
            $display("FAIL rm_resp: got resp=%b rd=%b data=%h want 1 0 %h", l2_resp, pmem_read, l2_rdata, e);
        end
        l2_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({l2_resp, l2_rdata} !== {1'b0, e}) begin
            n_errors++;
            $display("FAIL rm_oneshot: got resp=%b data=%h want 0 %h", l2_resp, l2_rdata, e);
        end
    endtask

    task automatic test_random();
        logic [255:0] shadow [logic [10:0]];
        logic [255:0] d, got, want;
        logic [10:0]  t;
        int lat;
        mem_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            t = 11'h300 + 11'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d = rand_line();
                do_write({t, 5'($urandom())}, d, 40, lat);
                n_checks++;
                if (lat < 0) begin n_errors++; $display("FAIL rnd_w%0d: got timeout want resp", i); end
                shadow[t] = d;
            end else begin
                want = shadow.exists(t) ? shadow[t] : mem_default(t);
                do_read({t, 5'($urandom())}, 40, lat, got);
                n_checks++;
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL rnd_r%0d: got lat=%0d data=%h want %h", i, lat, got, want);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 300 && !(wb_empty === 1'b1 && pmem_write === 1'b0); i++) @(negedge clk);
        mem_en = 1'b0;
        n_checks++;
        if ({wb_empty, 32'(pmem_viol)} !== {1'b1, 32'd0}) begin
            n_errors++;
            $display("FAIL rnd_end: got empty=%b violations=%0d want 1 0", wb_empty, pmem_viol);
        end
    endtask

    task automatic test_reset_mid_drain();
        int lat, n, act;
        do_write(16'h7000, rand_line(), 4, lat);
        wait_pmem_write(6, n);
        n_checks++;
        if (n < 0) begin n_errors++; $display("FAIL rd_start: got no drain want drain"); end
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pmem_write, wb_empty} !== 2'b01) begin
            n_errors++;
            $display("FAIL rd_drop: got wr/empty=%b want 01", {pmem_write, wb_empty});
        end
        reset_n = 1'b1;
        pulse_resp();
        act = 0;
        repeat (6) begin
            if (l2_resp !== 1'b0 || pmem_write !== 1'b0 || pmem_read !== 1'b0 || wb_empty !== 1'b1) act++;
            @(negedge clk);
        end
        n_checks++;
        if ({32'(act), l2_rdata} !== {32'd0, 256'd0}) begin
            n_errors++;
            $display("FAIL rd_late: got %0d active cycles rdata=%h want 0 and 0", act, l2_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_drain();
        test_read_hit();
        test_coalesce();
        test_full_wrap();
        test_read_miss();
        test_random();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
